// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// if_fetch_unit
//  MIPS instruction-fetch stage: PC register, word-addressed instruction memory with a loader
//  write port, and the IF/ID pipeline register. Supports stall, flush, branch/jump redirect and
//  sticky HALT detection.
//
//  Optional feature: define IF_ADDR_CHECK_EN to raise a sticky o_fault on a run cycle whose PC
//  is misaligned or outside the memory (4*MEM_DEPTH bytes). Without it, the PC wraps modulo
//  MEM_DEPTH words and o_fault is tied low.
//
//  MEM_DEPTH is expected to be a power of two (the word index is a bit slice of the address).
//
//  Ports
//   i_clk, i_reset_n          clock (rising edge), asynchronous active-low reset
//   i_enable                  global run enable; 0 freezes PC and IF/ID
//   i_stall                   hold PC and IF/ID
//   i_flush                   load a bubble into IF/ID
//   i_pc_src, i_target        redirect: next PC = i_target
//   i_write, i_wr_addr/data   loader write into instruction memory
//   o_instruction, o_pc       IF/ID instruction and its PC+4
//   o_fetch_pc                current PC register
//   o_valid                   IF/ID holds a real instruction
//   o_halt                    sticky, set when HALT_WORD is fetched
//   o_fault                   sticky address fault (IF_ADDR_CHECK_EN only)
// ---------------------------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int unsigned        NB_INST   = 32,
  parameter int unsigned        NB_ADDR   = 32,
  parameter int unsigned        MEM_DEPTH = 256,
  parameter logic [NB_ADDR-1:0] RESET_PC  = '0,
  parameter logic [NB_INST-1:0] HALT_WORD = '0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_pc_src,
  input  logic [NB_ADDR-1:0] i_target,
  input  logic               i_write,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_INST-1:0] i_wr_data,
  output logic [NB_INST-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_ADDR-1:0] o_fetch_pc,
  output logic               o_valid,
  output logic               o_halt,
  output logic               o_fault
);

  localparam int unsigned NB_IDX = $clog2(MEM_DEPTH);

  logic [NB_INST-1:0] r_mem [MEM_DEPTH];

  logic [NB_ADDR-1:0] r_pc;
  logic [NB_INST-1:0] r_inst;
  logic [NB_ADDR-1:0] r_pcp4;
  logic               r_valid;
  logic               r_halt;
  logic               r_fault;

  logic [NB_ADDR-1:0] w_pc_next;
  logic [NB_INST-1:0] w_inst_next;
  logic [NB_ADDR-1:0] w_pcp4_next;
  logic               w_valid_next;
  logic               w_halt_next;
  logic               w_fault_next;

  logic [NB_IDX-1:0]  w_rd_idx;
  logic [NB_IDX-1:0]  w_wr_idx;
  logic [NB_INST-1:0] w_rd_word;
  logic [NB_ADDR-1:0] w_pc_plus4;
  logic               w_addr_bad;
  logic               w_stopped;

  assign w_rd_idx   = r_pc[2 +: NB_IDX];
  assign w_wr_idx   = i_wr_addr[2 +: NB_IDX];
  assign w_rd_word  = r_mem[w_rd_idx];
  assign w_pc_plus4 = r_pc + NB_ADDR'(4);
  assign w_stopped  = r_halt | r_fault;

`ifdef IF_ADDR_CHECK_EN
  localparam logic [NB_ADDR:0] MEM_BYTES = (NB_ADDR+1)'(4 * MEM_DEPTH);
  assign w_addr_bad = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} >= MEM_BYTES);
`else
  assign w_addr_bad = 1'b0;
`endif

  // Address bits that never select a memory word.
  logic w_unused;
  assign w_unused = ^{i_wr_addr[1:0], i_wr_addr[NB_ADDR-1:NB_IDX+2],
                      r_pc[1:0], r_pc[NB_ADDR-1:NB_IDX+2]};

  // Memory is not reset; the loader fills it before fetch is enabled.
  always_ff @(posedge i_clk) begin
    if (i_write) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
  end

  // Priority: write > disabled > halted/faulted > flush/redirect > stall > run.
  always_comb begin
    w_pc_next    = r_pc;
    w_inst_next  = r_inst;
    w_pcp4_next  = r_pcp4;
    w_valid_next = r_valid;
    w_halt_next  = r_halt;
    w_fault_next = r_fault;

    if (i_write) begin
      // Reload: drop any stop condition so the new program can run.
      w_valid_next = 1'b0;
      w_halt_next  = 1'b0;
      w_fault_next = 1'b0;
    end else if (!i_enable) begin
      // Everything frozen.
    end else if (w_stopped) begin
      w_valid_next = 1'b0;
    end else begin
      // A late-resolved redirect wins over stall.
      if (i_pc_src) begin
        w_pc_next = i_target;
      end

      if (i_flush) begin
        w_valid_next = 1'b0;
        w_inst_next  = '0;
        w_pcp4_next  = '0;
      end else if (!i_stall) begin
        if (w_addr_bad) begin
          w_fault_next = 1'b1;
          w_valid_next = 1'b0;
        end else begin
          w_inst_next  = w_rd_word;
          w_pcp4_next  = w_pc_plus4;
          w_valid_next = 1'b1;
          if (w_rd_word == HALT_WORD) begin
            // HALT is delivered to ID, but the PC does not advance past it.
            w_halt_next = 1'b1;
          end else if (!i_pc_src) begin
            w_pc_next = w_pc_plus4;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_pcp4  <= '0;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_inst  <= w_inst_next;
      r_pcp4  <= w_pcp4_next;
      r_valid <= w_valid_next;
      r_halt  <= w_halt_next;
      r_fault <= w_fault_next;
    end
  end

  assign o_instruction = r_inst;
  assign o_pc          = r_pcp4;
  assign o_fetch_pc    = r_pc;
  assign o_valid       = r_valid;
  assign o_halt        = r_halt;
  assign o_fault       = r_fault;

endmodule
